// File: rtl/q_sample_averager_if.sv
// Sample/average bus for q_sample_averager: front-end sample stream in,
// windowed Q average and spike-reject count out.
interface q_sample_averager_if #(
  parameter int WIDTH = 10
);
  logic             enable;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic [WIDTH-1:0] q_measured;
  logic             q_valid;
  logic [7:0]       reject_cnt;

  modport master (
    output enable, sample_in, sample_valid,
    input  q_measured, q_valid, reject_cnt
  );

  modport slave (
    input  enable, sample_in, sample_valid,
    output q_measured, q_valid, reject_cnt
  );
endinterface

// File: rtl/q_sample_averager.sv
// Averages N = 2**AVG_LOG2 accepted Q samples into a registered q_measured.
// Optional spike rejection against the last published average: Q_SPIKE_REJECT_EN.
module q_sample_averager #(
  parameter int WIDTH     = 10,
  parameter int AVG_LOG2  = 2,
  parameter int SPIKE_LIM = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  q_sample_averager_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_meas_q;
  logic             q_valid_q;

  logic             take;
  logic             reject;
  logic             accept;
  logic             win_done;
  logic [ACC_W-1:0] acc_d;

  assign take     = bus.sample_valid && bus.enable && (state_q != IDLE);
  assign accept   = take && !reject;
  assign win_done = accept && (cnt_q == CNT_LAST);
  // Sum including the current sample; never overflows since acc_q holds at most N-1 samples.
  assign acc_d    = acc_q + ACC_W'(bus.sample_in);

  // NOTE: the async reset clears every register, including the accumulator, so a
  // reset mid-window can never leak a partial sum into the next average.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      q_meas_q  <= '0;
      q_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of acc_q/cnt_q regardless of statement order.
      q_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enable) state_q <= ACCUM;
        end
        default: begin
          if (!bus.enable) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else if (win_done) begin
            q_meas_q  <= WIDTH'(acc_d >> AVG_LOG2);
            q_valid_q <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= DONE;
          end else begin
            // A sample taken in DONE lands on the cleared accumulator as sample 1.
            state_q <= ACCUM;
            if (accept) begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.q_measured = q_meas_q;
  assign bus.q_valid    = q_valid_q;

`ifdef Q_SPIKE_REJECT_EN
  localparam int DW = WIDTH + 1;
  localparam logic [DW-1:0] LIM = DW'(SPIKE_LIM);

  logic                 ref_valid_q;
  logic [7:0]           rej_cnt_q;
  logic signed [DW-1:0] diff;
  logic [DW-1:0]        diff_abs;

  assign diff     = $signed({1'b0, bus.sample_in}) - $signed({1'b0, q_meas_q});
  assign diff_abs = diff[DW-1] ? $unsigned(-diff) : $unsigned(diff);
  // No reference exists until the first window has been published.
  assign reject   = take && ref_valid_q && (diff_abs > LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_valid_q <= 1'b0;
      rej_cnt_q   <= '0;
    end else begin
      if (win_done) ref_valid_q <= 1'b1;
      if (reject && (rej_cnt_q != 8'hFF)) rej_cnt_q <= rej_cnt_q + 8'd1;
    end
  end

  assign bus.reject_cnt = rej_cnt_q;
`else
  assign reject         = 1'b0;
  assign bus.reject_cnt = '0;
`endif

endmodule

// File: tb/tb_q_sample_averager.sv
// Directed, table-driven bench for q_sample_averager (default parameters);
// expectations follow Q_SPIKE_REJECT_EN when the macro is defined.
module tb_q_sample_averager;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  q_sample_averager_if #(.WIDTH(10)) bus_if ();

  q_sample_averager #(.WIDTH(10), .AVG_LOG2(2), .SPIKE_LIM(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

`ifdef Q_SPIKE_REJECT_EN
  localparam bit SPIKE_EN = 1'b1;
`else
  localparam bit SPIKE_EN = 1'b0;
`endif

  typedef struct {
    bit         do_rst;
    bit         en;
    bit         vld;
    logic [9:0] smp;
    bit         exp_qv;
    logic [9:0] exp_qm;
  } vec_t;

  vec_t vecs[$];
  int   checks    = 0;
  int   failures  = 0;
  int   qv_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit e, bit v, logic [9:0] s, bit qv, logic [9:0] qm);
    vec_t t;
    t.do_rst = r; t.en = e; t.vld = v; t.smp = s; t.exp_qv = qv; t.exp_qm = qm;
    return t;
  endfunction

  // Drive one cycle of inputs, then sample outputs 1 time unit after the rising edge.
  task automatic step(input bit en, input bit v, input logic [9:0] s);
    bus_if.enable       = en;
    bus_if.sample_valid = v;
    bus_if.sample_in    = s;
    @(posedge clk);
    #1;
    if (bus_if.q_valid) qv_pulses++;
  endtask

  task automatic do_reset();
    bus_if.enable       = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.sample_in    = '0;
    rst = 1'b0;
    #4;
    rst = 1'b1;
    qv_pulses = 0;
  endtask

  initial begin
    bus_if.enable       = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.sample_in    = '0;
    #12;
    rst = 1'b1;

    // Basic average, overflow, truncation and gap-stall windows.
    vecs.push_back(mk(1, 0, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 1,  100, 0,    0));
    vecs.push_back(mk(0, 1, 1,  200, 0,    0));
    vecs.push_back(mk(0, 1, 1,  300, 0,    0));
    vecs.push_back(mk(0, 1, 1,  400, 1,  250));
    vecs.push_back(mk(0, 1, 0,    0, 0,  250));
    vecs.push_back(mk(1, 0, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 1, 1023, 0,    0));
    vecs.push_back(mk(0, 1, 1, 1023, 0,    0));
    vecs.push_back(mk(0, 1, 1, 1023, 0,    0));
    vecs.push_back(mk(0, 1, 1, 1023, 1, 1023));
    vecs.push_back(mk(1, 0, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 1,    1, 0,    0));
    vecs.push_back(mk(0, 1, 1,    1, 0,    0));
    vecs.push_back(mk(0, 1, 1,    1, 0,    0));
    vecs.push_back(mk(0, 1, 1,    2, 1,    1));
    vecs.push_back(mk(1, 0, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 0,    0, 0,    0));
    vecs.push_back(mk(0, 1, 1,    8, 0,    0));
    for (int g = 0; g < 5; g++) vecs.push_back(mk(0, 1, 0, 999, 0, 0));
    vecs.push_back(mk(0, 1, 1,    8, 0,    0));
    vecs.push_back(mk(0, 1, 1,    8, 0,    0));
    vecs.push_back(mk(0, 1, 1,    8, 1,    8));

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      else step(vecs[i].en, vecs[i].vld, vecs[i].smp);
      check($sformatf("vec%0d_q_valid", i), bus_if.q_valid, vecs[i].exp_qv);
      check($sformatf("vec%0d_q_measured", i), bus_if.q_measured, vecs[i].exp_qm);
      check($sformatf("vec%0d_reject_cnt", i), bus_if.reject_cnt, 0);
    end

    // Sample presented in the DONE cycle starts the next window.
    do_reset();
    step(1, 0, 0);
    step(1, 1, 40); step(1, 1, 40); step(1, 1, 60);
    check("done_w1_early", bus_if.q_valid, 0);
    step(1, 1, 60);
    check("done_w1_qv", bus_if.q_valid, 1);
    check("done_w1_qm", bus_if.q_measured, 50);
    step(1, 1, 50);
    check("done_cycle_qv", bus_if.q_valid, 0);
    step(1, 1, 50); step(1, 1, 50);
    check("done_w2_early", bus_if.q_valid, 0);
    step(1, 1, 50);
    check("done_w2_qv", bus_if.q_valid, 1);
    check("done_w2_qm", bus_if.q_measured, 50);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    check("done_pulse_count", qv_pulses, 2);

    // Spike stimulus after a 250 reference.
    do_reset();
    step(1, 0, 0);
    step(1, 1, 100); step(1, 1, 200); step(1, 1, 300); step(1, 1, 400);
    check("spike_ref_qm", bus_if.q_measured, 250);
    step(1, 0, 0);
    step(1, 1, 250); step(1, 1, 900); step(1, 1, 260); step(1, 1, 240);
    check("spike_after240_qv", bus_if.q_valid, SPIKE_EN ? 0 : 1);
    check("spike_after240_qm", bus_if.q_measured, SPIKE_EN ? 250 : 412);
    step(1, 1, 250);
    check("spike_final_qv", bus_if.q_valid, SPIKE_EN ? 1 : 0);
    check("spike_final_qm", bus_if.q_measured, SPIKE_EN ? 250 : 412);
    check("spike_reject_cnt", bus_if.reject_cnt, SPIKE_EN ? 1 : 0);
    for (int k = 0; k < 300; k++) step(1, 1, 900);
    check("spike_reject_sat", bus_if.reject_cnt, SPIKE_EN ? 255 : 0);

    // Enable drop discards the partial window; async reset clears outputs at once.
    do_reset();
    step(1, 0, 0);
    step(1, 1, 30); step(1, 1, 30);
    for (int k = 0; k < 3; k++) step(0, 0, 0);
    check("dis_qv", bus_if.q_valid, 0);
    check("dis_qm", bus_if.q_measured, 0);
    step(1, 0, 0);
    step(1, 1, 10); step(1, 1, 10); step(1, 1, 10);
    check("dis_w_early", bus_if.q_valid, 0);
    step(1, 1, 10);
    check("dis_w_qv", bus_if.q_valid, 1);
    check("dis_w_qm", bus_if.q_measured, 10);
    step(0, 0, 0);
    check("idle_hold_qm", bus_if.q_measured, 10);
    check("idle_qv", bus_if.q_valid, 0);
    step(1, 0, 0);
    step(1, 1, 10); step(1, 1, 10);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_qm", bus_if.q_measured, 0);
    check("async_rst_qv", bus_if.q_valid, 0);
    check("async_rst_rc", bus_if.reject_cnt, 0);
    #1;
    rst = 1'b1;
    step(1, 0, 0);
    step(1, 1, 20); step(1, 1, 20); step(1, 1, 20);
    check("post_rst_early", bus_if.q_valid, 0);
    step(1, 1, 20);
    check("post_rst_qv", bus_if.q_valid, 1);
    check("post_rst_qm", bus_if.q_measured, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
